// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock enable.
// Optional colour-bar test pattern on `pixel` when VGA_TIMING_TESTPAT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [2:0]    pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] HT_M1 = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VT_M1 = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS0   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS0   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS1   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic          x_wrap;
  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          de_nxt;

  // Outputs are decoded from the next counter state so they line up with x/y.
  always_comb begin
    x_wrap = (x == HT_M1);
    x_nxt  = x_wrap ? '0 : x + ONE;
    y_nxt  = y;
    if (x_wrap)
      y_nxt = (y == VT_M1) ? '0 : y + ONE;
    hs_nxt = (x_nxt >= HS0) && (x_nxt < HS1);
    vs_nxt = (y_nxt >= VS0) && (y_nxt < VS1);
    de_nxt = (x_nxt < HA) && (y_nxt < VA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= HT_M1;
      y           <= VT_M1;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= hs_nxt ? H_POL : ~H_POL;
      vsync       <= vs_nxt ? V_POL : ~V_POL;
      de          <= de_nxt;
      line_start  <= (x_nxt == '0);
      frame_start <= (x_nxt == '0) && (y_nxt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_TESTPAT_EN
  localparam int BW = H_ACTIVE / 8;
  localparam logic [CW-1:0] BW_M1 = CW'(BW - 1);

  logic [2:0]    bar;
  logic [2:0]    bar_nxt;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] bcnt_nxt;

  // Bar 7 never advances, so it absorbs the H_ACTIVE % 8 remainder.
  always_comb begin
    bar_nxt  = bar;
    bcnt_nxt = bcnt + ONE;
    if (x_nxt == '0) begin
      bar_nxt  = 3'd0;
      bcnt_nxt = '0;
    end else if (bcnt == BW_M1 && bar != 3'd7) begin
      bar_nxt  = bar + 3'd1;
      bcnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar   <= 3'd0;
      bcnt  <= '0;
      pixel <= 3'd0;
    end else if (pix_ce) begin
      bar   <= bar_nxt;
      bcnt  <= bcnt_nxt;
      pixel <= de_nxt ? bar_nxt : 3'd0;
    end
  end
`else
  assign pixel = 3'b000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster.
// Reference model tracks (x,y) and derives every output independently.
module tb_vga_timing_gen;

  localparam int HA = 20, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CW = 6;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;

  typedef struct {
    int x; int y; int hs; int vs;
    int de; int ls; int fs; int px;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_ce = 1'b0;
  logic          hsync, vsync, de;
  logic [CW-1:0] x, y;
  logic          line_start, frame_start;
  logic [2:0]    pixel;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start),
    .pixel(pixel)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   mx = HT - 1;
  int   my = VT - 1;
  int   mls = 0;
  int   mfs = 0;
  int   cyc = 0;
  int   last_fs = -1;
  int   last_ls = -1;
  int   fper = 0;
  int   lper = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (mx=%0d my=%0d t=%0t)",
               tag, got, exp, mx, my, $time);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    int   b;
    e.x  = mx;
    e.y  = my;
    e.hs = (mx >= HA + HF && mx < HA + HF + HS) ? int'(HP) : int'(!HP);
    e.vs = (my >= VA + VF && my < VA + VF + VS) ? int'(VP) : int'(!VP);
    e.de = (mx < HA && my < VA) ? 1 : 0;
    e.ls = mls;
    e.fs = mfs;
    b = mx / (HA / 8);
    if (b > 7) b = 7;
`ifdef VGA_TIMING_TESTPAT_EN
    e.px = e.de ? b : 0;
`else
    e.px = 0;
`endif
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    e = q.pop_front();
    check("x", int'(x), e.x);
    check("y", int'(y), e.y);
    check("hsync", int'(hsync), e.hs);
    check("vsync", int'(vsync), e.vs);
    check("de", int'(de), e.de);
    check("line_start", int'(line_start), e.ls);
    check("frame_start", int'(frame_start), e.fs);
    check("pixel", int'(pixel), e.px);
  endtask

  task automatic step(input bit ce);
    pix_ce = ce;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mx = HT - 1; my = VT - 1; mls = 0; mfs = 0;
    end else if (ce) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      mls = (mx == 0) ? 1 : 0;
      mfs = (mx == 0 && my == 0) ? 1 : 0;
    end else begin
      mls = 0; mfs = 0;
    end
    q.push_back(model());
    #1;
    compare_out();
    if (frame_start) begin
      if (last_fs >= 0 && fper > 0) check("fs_period", cyc - last_fs, fper);
      last_fs = cyc;
    end
    if (line_start) begin
      if (last_ls >= 0 && lper > 0) check("ls_period", cyc - last_ls, lper);
      last_ls = cyc;
    end
  endtask

  task automatic new_phase(input int fp, input int lp);
    fper = fp; lper = lp; last_fs = -1; last_ls = -1;
  endtask

  initial begin
    int n;
    new_phase(0, 0);
    // Reset state, with and without enable
    step(1'b0);
    step(1'b1);
    step(1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous enable: first edge gives (0,0) and both strobes
    new_phase(FT, HT);
    for (int i = 0; i < 2 * FT + 3; i++) step(1'b1);

    // Enable every 4th clock: periods scale by 4
    new_phase(4 * FT, 4 * HT);
    for (int i = 0; i < 4 * FT + 4 * HT * 2; i++) step(i % 4 == 3);

    // Seek to mid-frame, then asynchronous reset between edges
    new_phase(0, 0);
    n = 0;
    while (!(mx == 10 && my == 5) && n < 2 * FT) begin
      step(1'b1);
      n++;
    end
    check("seek", (mx == 10 && my == 5) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    check("arst_x", int'(x), HT - 1);
    check("arst_y", int'(y), VT - 1);
    check("arst_de", int'(de), 0);
    check("arst_hs", int'(hsync), int'(!HP));
    check("arst_vs", int'(vsync), int'(!VP));
    check("arst_px", int'(pixel), 0);
    mx = HT - 1; my = VT - 1; mls = 0; mfs = 0;
    step(1'b1);
    step(1'b1);
    rst_n = 1'b1;
    step(1'b1);
    check("rst_fs", int'(frame_start), 1);

    // Random enables
    for (int i = 0; i < 3 * FT; i++) step(1'($urandom_range(0, 1)));

    check("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
